up_drp_arbiter: RTL and testbench

Round-robin arbiter that shares one DRP port (clock/transceiver dynamic reconfiguration) between up to four register-side requesters in the processor clock domain. Typical requesters: the common ADC/DAC register block's DRP access registers, a calibration sequencer and a test engine. Each requester issues a single read or write. The arbiter serialises the accesses onto the DRP port, waits for the ready strobe, and returns read data and a completion pulse to the owner.

---
 rtl/up_drp_arbiter.sv | 165 ++++++++++++++++
 tb/tb_up_drp_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/up_drp_arbiter.sv
// Round-robin arbiter sharing one DRP port between NUM_REQ processor-side requesters.
// Optional WAIT timeout is compiled in with `define DRP_ARB_TIMEOUT_EN.
module up_drp_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1023
) (
  input  logic                  up_clk,
  input  logic                  up_rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ*12-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    req_err,
  output logic [31:0]           req_rdata,
  output logic                  drp_sel,
  output logic                  drp_wr,
  output logic [11:0]           drp_addr,
  output logic [31:0]           drp_wdata,
  input  logic [31:0]           drp_rdata,
  input  logic                  drp_ready,
  output logic                  busy
);

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       last_grant, last_grant_d;
  logic [IDX_W-1:0]       grant, grant_d;
  logic [IDX_W-1:0]       pick, cand;
  logic                   found;
  logic                   tmo_hit;

  logic [NUM_REQ-1:0]     ack_d, err_d;
  logic [DW-1:0]          rdata_d, wdata_d;
  logic [AW-1:0]          addr_d;
  logic                   sel_d, wr_d, busy_d;

  logic [AW-1:0]          addr_arr  [NUM_REQ];
  logic [DW-1:0]          wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[AW*i +: AW];
    assign wdata_arr[i] = req_wdata[DW*i +: DW];
  end

  // First valid requester searching upward from last_grant+1
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef DRP_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Cleared while issuing, so it starts at 0 on entry to WAIT
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn)                          tmo_cnt <= '0;
    else if (state == S_ISSUE)             tmo_cnt <= '0;
    else if (state == S_WAIT && !drp_ready) tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = (state == S_WAIT) && !drp_ready && (tmo_cnt == TIMEOUT_CYCLES - 16'd1);
`else
  // Timeout length only matters in the timeout build; this folds to 0
  assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES == 16'd0);
`endif

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (drp_ready || tmo_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and arbitration state
  always_comb begin
    ack_d        = '0;
    err_d        = '0;
    rdata_d      = '0;
    sel_d        = 1'b0;
    wr_d         = 1'b0;
    addr_d       = drp_addr;
    wdata_d      = drp_wdata;
    grant_d      = grant;
    last_grant_d = last_grant;
    busy_d       = (state_nxt != S_IDLE);
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_d      = pick;
          last_grant_d = pick;
          sel_d        = 1'b1;
          wr_d         = req_wr[pick];
          addr_d       = addr_arr[pick];
          wdata_d      = wdata_arr[pick];
        end
      end
      S_WAIT: begin
        if (drp_ready) begin
          ack_d[grant] = 1'b1;
          rdata_d      = drp_rdata;
        end else if (tmo_hit) begin
          ack_d[grant] = 1'b1;
          err_d[grant] = 1'b1;
          rdata_d      = 32'hffff_ffff;
        end
      end
      S_DONE: begin
        addr_d  = '0;
        wdata_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      req_ack    <= '0;
      req_err    <= '0;
      req_rdata  <= '0;
      drp_sel    <= 1'b0;
      drp_wr     <= 1'b0;
      drp_addr   <= '0;
      drp_wdata  <= '0;
      busy       <= 1'b0;
      grant      <= '0;
      last_grant <= LAST_IDX;
    end else begin
      req_ack    <= ack_d;
      req_err    <= err_d;
      req_rdata  <= rdata_d;
      drp_sel    <= sel_d;
      drp_wr     <= wr_d;
      drp_addr   <= addr_d;
      drp_wdata  <= wdata_d;
      busy       <= busy_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_up_drp_arbiter.sv
// Directed bench for up_drp_arbiter with three requesters; timeout checks follow
// whether DRP_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
module tb_up_drp_arbiter;

  logic        up_clk;
  logic        up_rstn;
  logic [2:0]  req_valid;
  logic [2:0]  req_wr;
  logic [35:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  req_ack;
  logic [2:0]  req_err;
  logic [31:0] req_rdata;
  logic        drp_sel;
  logic        drp_wr;
  logic [11:0] drp_addr;
  logic [31:0] drp_wdata;
  logic [31:0] drp_rdata;
  logic        drp_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic prev_sel = 1'b0;

  up_drp_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(16'd8)) dut (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
    .drp_sel(drp_sel), .drp_wr(drp_wr), .drp_addr(drp_addr), .drp_wdata(drp_wdata),
    .drp_rdata(drp_rdata), .drp_ready(drp_ready), .busy(busy)
  );

  initial begin
    up_clk = 1'b0;
    forever #5 up_clk = ~up_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge up_clk);
    #1;
  endtask

  // drp_sel must never be high on two consecutive cycles
  always @(negedge up_clk) begin
    if (up_rstn && prev_sel) begin
      checks++;
      assert (drp_sel === 1'b0) else begin
        errors++;
        $error("FAIL sel_consecutive observed %0b expected 0", drp_sel);
      end
    end
    prev_sel = drp_sel;
  end

  initial begin
    up_rstn   = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    drp_rdata = '0;
    drp_ready = 1'b0;
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_sel", 32'(drp_sel), 32'd0);
    up_rstn = 1'b1;
    tick();

    // Single read by requester 0, ready one cycle after drp_sel
    req_valid = 3'b001;
    req_addr[11:0] = 12'h05c;
    tick();
    chk("rd_sel", 32'(drp_sel), 32'd1);
    chk("rd_wr", 32'(drp_wr), 32'd0);
    chk("rd_addr", 32'(drp_addr), 32'h05c);
    chk("rd_busy", 32'(busy), 32'd1);
    tick();
    chk("rd_sel_low", 32'(drp_sel), 32'd0);
    drp_ready = 1'b1;
    drp_rdata = 32'h0000_a5a5;
    tick();
    chk("rd_ack", 32'(req_ack), 32'b001);
    chk("rd_rdata", req_rdata, 32'h0000_a5a5);
    chk("rd_err", 32'(req_err), 32'd0);
    drp_ready = 1'b0;
    drp_rdata = '0;
    req_valid = '0;
    tick();
    chk("rd_ack_clr", 32'(req_ack), 32'd0);
    chk("rd_rdata_clr", req_rdata, 32'd0);
    chk("rd_idle_busy", 32'(busy), 32'd0);
    chk("rd_addr_clr", 32'(drp_addr), 32'd0);

    // Write by requester 1; fields changed after grant must not matter
    req_valid = 3'b010;
    req_wr    = 3'b010;
    req_addr[23:12]  = 12'h010;
    req_wdata[63:32] = 32'h0000_1234;
    tick();
    chk("wr_sel", 32'(drp_sel), 32'd1);
    chk("wr_wr", 32'(drp_wr), 32'd1);
    chk("wr_addr", 32'(drp_addr), 32'h010);
    chk("wr_wdata", drp_wdata, 32'h0000_1234);
    req_addr[23:12]  = 12'hfff;
    req_wdata[63:32] = 32'hbad0_bad0;
    tick();
    chk("wr_wr_low", 32'(drp_wr), 32'd0);
    chk("wr_hold_addr", 32'(drp_addr), 32'h010);
    chk("wr_hold_wdata", drp_wdata, 32'h0000_1234);
    tick();
    chk("wr_wait_ack", 32'(req_ack), 32'd0);
    drp_ready = 1'b1;
    tick();
    chk("wr_ack", 32'(req_ack), 32'b010);
    drp_ready = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    tick();
    chk("wr_idle_busy", 32'(busy), 32'd0);

    // Stray ready in IDLE, then a read by requester 2 that waits for ready
    drp_ready = 1'b1;
    drp_rdata = 32'hdead_beef;
    tick();
    drp_ready = 1'b0;
    chk("stray_ack", 32'(req_ack), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);
    tick();
    chk("stray_ack2", 32'(req_ack), 32'd0);
    req_valid = 3'b100;
    req_addr[35:24] = 12'h7ff;
    tick();
    chk("st_sel", 32'(drp_sel), 32'd1);
    chk("st_addr", 32'(drp_addr), 32'h7ff);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_wait_ack", 32'(req_ack), 32'd0);
      chk("st_wait_busy", 32'(busy), 32'd1);
    end
    drp_ready = 1'b1;
    drp_rdata = 32'h1357_9bdf;
    tick();
    chk("st_ack", 32'(req_ack), 32'b100);
    chk("st_rdata", req_rdata, 32'h1357_9bdf);
    drp_ready = 1'b0;
    req_valid = '0;
    tick();

    // Reset during WAIT drops the access and restores the pointer
    req_valid = 3'b001;
    req_addr[11:0] = 12'h123;
    tick();
    tick();
    up_rstn   = 1'b0;
    req_valid = '0;
    drp_ready = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(drp_addr), 32'd0);
    chk("mid_rst_ack", 32'(req_ack), 32'd0);
    tick();
    tick();
    up_rstn = 1'b1;
    tick();
    drp_ready = 1'b0;
    chk("post_rst_ack", 32'(req_ack), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    tick();
    chk("post_rst_ack2", 32'(req_ack), 32'd0);

    // Contention: all valid continuously, grants rotate starting at 0
    req_valid = 3'b111;
    req_wr    = '0;
    req_addr  = {12'ha02, 12'ha01, 12'ha00};
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("rr_addr", 32'(drp_addr), 32'ha00 + 32'(n % 3));
      tick();
      drp_ready = 1'b1;
      drp_rdata = 32'h100 + 32'(n);
      tick();
      chk("rr_ack", 32'(req_ack), 32'(1 << (n % 3)));
      chk("rr_rdata", req_rdata, 32'h100 + 32'(n));
      drp_ready = 1'b0;
      tick();
    end
    req_valid = '0;
    tick();
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // DRP never ready
    req_valid = 3'b010;
    req_addr[23:12] = 12'h03c;
    tick();
    tick();
`ifdef DRP_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    chk("to_pre_ack", 32'(req_ack), 32'd0);
    tick();
    chk("to_ack", 32'(req_ack), 32'b010);
    chk("to_err", 32'(req_err), 32'b010);
    chk("to_rdata", req_rdata, 32'hffff_ffff);
    req_valid = '0;
    tick();
    chk("to_err_clr", 32'(req_err), 32'd0);
    chk("to_idle_busy", 32'(busy), 32'd0);
`else
    repeat (40) tick();
    chk("hang_busy", 32'(busy), 32'd1);
    chk("hang_ack", 32'(req_ack), 32'd0);
    chk("hang_err", 32'(req_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
